mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller that sequences the shared 32-bit ALU for MIPS MULT and DIVU.
- Owns the architectural HI/LO registers and handles MTHI/MTLO writes.
- Drives the stall (`busy`) back to the EX stage.
- Models pipelined mul/div latency by holding ALU operands stable for a programmed number of cycles, then capturing R/R2 into LO/HI.

Parameters:
- MUL_LAT, 4, cycles from accept to HI/LO update for MULT; legal range 1..63.
- DIV_LAT, 32, cycles from accept to HI/LO update for DIVU; legal range 1..63.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a mul/div operation; sampled only in IDLE.
- is_div  in  1  with start: 0 = MULT (signed), 1 = DIVU (unsigned).
- rs_val  in  32  dividend / multiplicand.
- rt_val  in  32  divisor / multiplier.
- mthi  in  1  write hi_wdata into HI.
- mtlo  in  1  write lo_wdata into LO.
- hi_wdata  in  32  MTHI data.
- lo_wdata  in  32  MTLO data.
- flush  in  1  abort any in-flight operation (exception/branch squash).
- alu_x  out  32  ALU X operand.
- alu_y  out  32  ALU Y operand.
- alu_op  out  4  ALU OP: 3 = signed multiply, 4 = unsigned divide, 0 when idle.
- alu_r  in  32  ALU R (low product / quotient).
- alu_r2  in  32  ALU R2 (high product / remainder).
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  operation in flight; EX stage stalls on any mul/div/mfhi/mflo/mthi/mtlo while high.
- done  out  1  one-cycle pulse in the cycle after HI/LO were updated by an operation.
- div0  out  1  one-cycle pulse, same timing as done, when a DIVU with divisor 0 completed.

Behaviour:
- Reset (rst=1 at a clk edge, takes priority over all inputs, including mid-operation): state=IDLE.
  - hi=lo=0, alu_x=alu_y=0, alu_op=0.
  - busy=done=div0=0.
  - Counter=0.
- States: IDLE, BUSY.
- IDLE, start=1 (and flush=0):
  - Latch rs_val→alu_x, rt_val→alu_y, alu_op=4 if is_div else 3.
  - Load counter with (is_div ? DIV_LAT : MUL_LAT) - 1.
  - Record the div-by-zero condition (is_div && rt_val==0).
  - Go to BUSY. busy=1 from the next cycle.
- IDLE, mthi/mtlo:
  - Write hi/lo at the clk edge; visible the next cycle.
  - Both may assert together.
  - If start is also high, start wins and mthi/mtlo are dropped; the pipeline never issues both.
- BUSY, counter != 0:
  - Decrement the counter.
  - alu_x/alu_y/alu_op stay constant, so ALU inputs are stable for the full latency.
- BUSY, counter == 0:
  - If not div-by-zero: hi<=alu_r2, lo<=alu_r.
  - If div-by-zero: hi/lo unchanged and div0 pulses.
  - done pulses 1 cycle.
  - Go to IDLE; alu_op<=0. alu_x/alu_y hold their values.
- Latency: accept at edge k → busy high for cycles k+1..k+LAT → hi/lo updated at edge k+LAT → done=1 during cycle k+LAT+1, busy=0 in that cycle.
- A new start may be accepted at edge k+LAT+1.
- In BUSY, start/mthi/mtlo are ignored: no re-latch and no HI/LO write.
- flush=1 (rst=0):
  - In BUSY: go to IDLE at that edge; hi/lo unchanged, done=div0=0, alu_op=0.
  - In IDLE: suppresses start and mthi/mtlo that cycle.
  - A flush on the completing edge (counter==0) also aborts; HI/LO are not written.
- Arithmetic rules:
  - Multiply is 32x32 signed → 64 bits {R2,R}.
  - Divide is unsigned; R = quotient, R2 = remainder.
  - No widening or sign handling occurs inside this block.
- done and div0 are registered outputs and never high in consecutive cycles.

Test Plan:
- MULT: rs=0xFFFFFFFE, rt=3, MUL_LAT=4.
  - Required: busy high 4 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Required: done pulses once, 5 cycles after accept; alu_op=3 and alu_x/alu_y constant throughout.
- DIVU: rs=100, rt=7, DIV_LAT=32.
  - Required: LO=14, HI=2 at edge accept+32.
  - Required: start re-pulsed with rs=9,rt=9 during busy is ignored; final result is still 14/2.
- DIVU by zero: HI=0x11, LO=0x22 preloaded via mthi/mtlo; issue rs=5, rt=0.
  - Required: after 32 cycles, done=1 and div0=1; HI=0x11, LO=0x22.
- Flush: issue DIVU 100/7, assert flush at busy cycle 10.
  - Required: busy=0 next cycle, done never pulses, HI/LO keep their prior values.
  - Required: an immediately following MULT 6*7 gives LO=42, HI=0.
- MTHI/MTLO: in IDLE, mthi=1 hi_wdata=0xDEADBEEF together with mtlo=1 lo_wdata=0x12345678.
  - Required: both registers are updated next cycle.
  - Required: the same pair issued with start=1 drops the writes; the MULT result overwrites HI/LO.
- Reset mid-operation: rst=1 at busy cycle 2 of a MULT.
  - Required: hi=lo=0, busy=done=div0=0, alu_op=0 next cycle.
  - Required: no later done pulse.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: holds shared-ALU operands stable for a fixed
// latency, then captures R/R2 into LO/HI. Also owns MTHI/MTLO writes.
module mdu_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_div,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  input  logic        flush,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_r,
  input  logic [31:0] alu_r2,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO accepted
  // BUSY  | operands held on the ALU while the latency counter runs down
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;

  state_t     state;
  logic [5:0] cnt;
  logic       dz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dz     <= 1'b0;
      alu_x  <= '0;
      alu_y  <= '0;
      alu_op <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush) begin
            // start takes precedence; the pipeline never pairs it with MTHI/MTLO
            if (start) begin
              alu_x  <= rs_val;
              alu_y  <= rt_val;
              alu_op <= is_div ? OP_DIV : OP_MUL;
              cnt    <= is_div ? DIV_LOAD : MUL_LOAD;
              dz     <= is_div && (rt_val == 32'd0);
              busy   <= 1'b1;
              state  <= BUSY;
            end else begin
              if (mthi) hi <= hi_wdata;
              if (mtlo) lo <= lo_wdata;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            cnt    <= '0;
            alu_op <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
          end else begin
            // divide by zero leaves HI/LO untouched and flags it instead
            if (!dz) begin
              hi <= alu_r2;
              lo <= alu_r;
            end
            div0   <= dz;
            done   <= 1'b1;
            alu_op <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: behavioural ALU, scoreboard of expected
// HI/LO results pushed at issue and popped when done pulses.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, is_div, mthi, mtlo, flush;
  logic [31:0] rs_val, rt_val, hi_wdata, lo_wdata;
  logic [31:0] alu_x, alu_y, alu_r, alu_r2, hi, lo;
  logic [3:0]  alu_op;
  logic        busy, done, div0;

  always #5 clk = ~clk;

  mdu_sequencer #(.MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_div(is_div),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .flush(flush),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_r(alu_r), .alu_r2(alu_r2), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div0(div0)
  );

  // Behavioural ALU: signed 32x32 multiply, unsigned divide.
  always_comb begin
    logic signed [63:0] p;
    p      = '0;
    alu_r  = '0;
    alu_r2 = '0;
    if (alu_op == 4'd3) begin
      p      = $signed(alu_x) * $signed(alu_y);
      alu_r  = p[31:0];
      alu_r2 = p[63:32];
    end else if (alu_op == 4'd4) begin
      if (alu_y != 32'd0) begin
        alu_r  = alu_x / alu_y;
        alu_r2 = alu_x % alu_y;
      end else begin
        alu_r  = 32'hFFFF_FFFF;
        alu_r2 = alu_x;
      end
    end
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic d, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    logic signed [63:0] p;
    start  = 1'b1;
    is_div = d;
    rs_val = a;
    rt_val = b;
    if (push) begin
      e.dz = d && (b == 32'd0);
      if (!d) begin
        p    = $signed(a) * $signed(b);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end else if (b == 32'd0) begin
        e.hi = m_hi;
        e.lo = m_lo;
      end else begin
        e.hi = a % b;
        e.lo = a / b;
      end
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
  endtask

  // Called in the first cycle after accept; runs the op to completion.
  task automatic wait_done(input int lat, input logic [3:0] op, input string tag, input bit restart);
    int          cyc  = 0;
    int          nbad = 0;
    logic [31:0] x0, y0;
    exp_t        e;
    x0 = alu_x;
    y0 = alu_y;
    chk({tag, ".alu_op"}, 64'(alu_op), 64'(op));
    while (busy === 1'b1 && cyc < 200) begin
      if (alu_x !== x0 || alu_y !== y0 || alu_op !== op) nbad++;
      if (done === 1'b1 || hi !== m_hi || lo !== m_lo) nbad++;
      cyc++;
      if (restart && cyc == 3) begin
        start  = 1'b1;
        is_div = 1'b1;
        rs_val = 32'd9;
        rt_val = 32'd9;
      end
      tick();
      start = 1'b0;
    end
    chk({tag, ".busy_cycles"}, 64'(cyc), 64'(lat));
    chk({tag, ".stable"}, 64'(nbad), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".alu_op_idle"}, 64'(alu_op), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, ".sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".div0"}, 64'(div0), 64'(e.dz));
      chk({tag, ".hi"}, 64'(hi), 64'(e.hi));
      chk({tag, ".lo"}, 64'(lo), 64'(e.lo));
      m_hi = e.hi;
      m_lo = e.lo;
    end
    tick();
    chk({tag, ".done_once"}, {63'd0, done}, 64'd0);
    chk({tag, ".div0_once"}, {63'd0, div0}, 64'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; is_div = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    rs_val = '0; rt_val = '0; hi_wdata = '0; lo_wdata = '0;
    m_hi = '0; m_lo = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.alu", {alu_x, alu_y}, 64'd0);
    chk("rst.flags", {59'd0, alu_op, busy}, 64'd0);
    chk("rst.pulses", {62'd0, done, div0}, 64'd0);

    // MULT -2 * 3
    issue(1'b0, 32'hFFFF_FFFE, 32'd3, 1'b1);
    chk("mul.busy_next", 64'(busy), 64'd1);
    wait_done(4, 4'd3, "mul", 1'b0);

    // DIVU 100/7 with an ignored restart in the middle
    issue(1'b1, 32'd100, 32'd7, 1'b1);
    wait_done(32, 4'd4, "divu", 1'b1);

    // MTHI/MTLO preload, then DIVU by zero
    mthi = 1'b1; hi_wdata = 32'h11; mtlo = 1'b1; lo_wdata = 32'h22;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    m_hi = 32'h11; m_lo = 32'h22;
    chk("mt.hi", 64'(hi), 64'h11);
    chk("mt.lo", 64'(lo), 64'h22);
    issue(1'b1, 32'd5, 32'd0, 1'b1);
    wait_done(32, 4'd4, "div0", 1'b0);

    // Flush at busy cycle 10, then an immediate MULT 6*7
    issue(1'b1, 32'd100, 32'd7, 1'b0);
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    chk("flush.done", {62'd0, done, div0}, 64'd0);
    chk("flush.hilo", {hi, lo}, {32'h11, 32'h22});
    issue(1'b0, 32'd6, 32'd7, 1'b1);
    wait_done(4, 4'd3, "mul67", 1'b0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("flush.no_late_done", 64'(ndone), 64'd0);

    // MTHI/MTLO together in IDLE
    mthi = 1'b1; hi_wdata = 32'hDEAD_BEEF; mtlo = 1'b1; lo_wdata = 32'h1234_5678;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;
    chk("mt2.hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});

    // Same writes alongside start: dropped, MULT result lands
    mthi = 1'b1; hi_wdata = 32'hAAAA_5555; mtlo = 1'b1; lo_wdata = 32'h5555_AAAA;
    issue(1'b0, 32'd3, 32'd5, 1'b1);
    chk("mtstart.dropped", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});
    wait_done(4, 4'd3, "mtstart", 1'b0);

    // Reset at busy cycle 2 of a MULT
    issue(1'b0, 32'd1000, 32'd1000, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.hilo", {hi, lo}, 64'd0);
    chk("midrst.flags", {59'd0, alu_op, busy}, 64'd0);
    chk("midrst.pulses", {62'd0, done, div0}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      tick();
    end
    chk("midrst.quiet", 64'(ndone), 64'd0);
    chk("sb.drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
